// File: rtl/maxpool_2x2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maxpool_2x2_pkg                                                      |
// | Shared constants, state type and signed pixel max for maxpool_2x2.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package maxpool_2x2_pkg;

  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic [0:0] {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } pool_state_t;

  // Signed int8 max; on a tie both operands are equal so either is correct.
  function automatic logic [PIX_W-1:0] smax8(input logic [PIX_W-1:0] a,
                                             input logic [PIX_W-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_2x2_pool_line_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_line_buf                                                        |
// | Synchronous-write, combinational-read RAM of horizontal row maxima. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pool_line_buf
  import maxpool_2x2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [2*PIX_W-1:0]   wdata,
  input  logic [AW-1:0]        raddr,
  output logic [2*PIX_W-1:0]   rdata
);

  logic [2*PIX_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/maxpool_2x2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maxpool_2x2                                                          |
// | 2x2 stride-2 max pooling over a packed int8 row stream.              |
// | Optional macro MAXPOOL_RELU_EN clamps negative input bytes to zero.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module maxpool_2x2
  import maxpool_2x2_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
);

  localparam int COLS = IMG_W / PIX_PER_WORD;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  pool_state_t          r_state;
  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;
  logic [2*PIX_W-1:0]   r_half;
  logic                 r_out_valid;
  logic [31:0]          r_out_data;
  logic                 r_out_last;

  logic [PIX_W-1:0]     w_pix [PIX_PER_WORD];
  logic [PIX_W-1:0]     w_h0;
  logic [PIX_W-1:0]     w_h1;
  logic [PIX_W-1:0]     w_v0;
  logic [PIX_W-1:0]     w_v1;
  logic [2*PIX_W-1:0]   w_rd;
  logic                 w_accept;
  logic                 w_last_col;
  logic                 w_last_row;
  logic                 w_buf_we;

  generate
    for (genvar g = 0; g < PIX_PER_WORD; g++) begin : g_pix
`ifdef MAXPOOL_RELU_EN
      assign w_pix[g] = in_data[PIX_W*g + PIX_W-1] ? '0 : in_data[PIX_W*g +: PIX_W];
`else
      assign w_pix[g] = in_data[PIX_W*g +: PIX_W];
`endif
    end
  endgenerate

  assign w_h0 = smax8(w_pix[0], w_pix[1]);
  assign w_h1 = smax8(w_pix[2], w_pix[3]);
  assign w_v0 = smax8(w_h0, w_rd[PIX_W-1:0]);
  assign w_v1 = smax8(w_h1, w_rd[2*PIX_W-1:PIX_W]);

  // Ready depends only on registered state and out_ready, never on in_valid.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_last_col = (r_col == LAST_COL);
  assign w_last_row = (r_row == LAST_ROW);
  assign w_buf_we   = w_accept && (r_state == ROW_EVEN);

  pool_line_buf #(
    .DEPTH (COLS),
    .AW    (CW)
  ) u_line_buf (
    .clk   (clk),
    .we    (w_buf_we),
    .waddr (r_col),
    .wdata ({w_h1, w_h0}),
    .raddr (r_col),
    .rdata (w_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ROW_EVEN;
      r_col       <= '0;
      r_row       <= '0;
      r_half      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_last_col) begin
          r_col   <= '0;
          r_state <= (r_state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
          r_row   <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col   <= r_col + 1'b1;
        end
        if (r_state == ROW_ODD) begin
          if (!r_col[0]) begin
            r_half <= {w_v1, w_v0};
          end else begin
            // A completing word overrides the clear above, so out_valid stays high.
            r_out_data  <= {w_v1, w_v0, r_half};
            r_out_valid <= 1'b1;
            r_out_last  <= w_last_col && w_last_row;
          end
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_row != '0) || (r_col != '0);

endmodule
`default_nettype wire
